// File: rtl/kf_pkg.sv
// kf_pkg: constants, frontend FSM state type and fixed-point helpers shared by
// meas_frontend and kalman_filter.
package kf_pkg;

    localparam int STATE_BITS = 16;
    localparam int STATE_Q    = 15;

    typedef enum logic {
        ST_CAL = 1'b0,
        ST_RUN = 1'b1
    } fe_state_t;

    // Arithmetic right shift by sh with rounding half away from zero.
    function automatic logic signed [31:0] round_shr(input logic signed [31:0] x,
                                                     input int unsigned sh);
        logic signed [31:0] half;
        if (sh == 0) return x;
        half = 32'sd1 <<< (sh - 1);
        if (x >= 0) return (x + half) >>> sh;
        return -((-x + half) >>> sh);
    endfunction

    // Clamp x into the signed range of a bits-wide two's complement value.
    function automatic logic signed [31:0] saturate(input logic signed [31:0] x,
                                                    input int unsigned bits);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (bits - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/meas_frontend_if.sv
// meas_frontend_if: raw sample stream in, measurement stream out.
// The master side produces raw samples and consumes measurements.
interface meas_frontend_if #(
    parameter int RAW_BITS   = 12,
    parameter int STATE_BITS = 16
);
    logic [RAW_BITS-1:0]   raw_in;
    logic                  raw_valid;
    logic                  raw_ready;
    logic [STATE_BITS-1:0] z_out;
    logic                  z_valid;
    logic                  z_ready;

    modport master (
        output raw_in, raw_valid, z_ready,
        input  raw_ready, z_out, z_valid
    );

    modport slave (
        input  raw_in, raw_valid, z_ready,
        output raw_ready, z_out, z_valid
    );
endinterface

// File: rtl/meas_accum.sv
// meas_accum: signed accumulator plus accepted-sample counter.
// clr wins over load; load adds addend and bumps the counter.
module meas_accum #(
    parameter int ACC_W = 17,
    parameter int CNT_W = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    load,
    input  logic signed [ACC_W-1:0] addend,
    output logic signed [ACC_W-1:0] sum_next,
    output logic [CNT_W-1:0]        cnt
);
    logic signed [ACC_W-1:0] sum;

    assign sum_next = sum + addend;

    // Accumulator and counter registers.
    // NOTE: state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
            cnt <= '0;
        end else if (clr) begin
            sum <= '0;
            cnt <= '0;
        end else if (load) begin
            sum <= sum_next;
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/meas_frontend.sv
// meas_frontend: offset-binary sensor samples -> offset removal -> averaging
// decimation -> saturated signed Q15 measurement stream.
// Optional feature macro MEAS_OFFSET_CAL_EN: offset calibration (CAL state,
// recal, cal_done). Without it the offset is fixed at mid-scale.
module meas_frontend #(
    parameter int RAW_BITS   = 12,
    parameter int STATE_BITS = kf_pkg::STATE_BITS,
    parameter int STATE_Q    = kf_pkg::STATE_Q,
    parameter int DEC_LOG2   = 2,
    parameter int CAL_LOG2   = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    meas_frontend_if.slave bus,
    input  logic           recal,
    output logic           cal_done,
    output logic           sat_flag
);
    import kf_pkg::*;

    localparam int SHIFT = STATE_BITS - RAW_BITS;
    localparam int CAL_W = RAW_BITS + CAL_LOG2;
    localparam int RUN_W = RAW_BITS + 1 + DEC_LOG2;
    // One spare bit so the unsigned CAL sum stays positive in a signed register.
    localparam int ACC_W = ((CAL_W > RUN_W) ? CAL_W : RUN_W) + 1;
    localparam int CNT_W = ((CAL_LOG2 > DEC_LOG2) ? CAL_LOG2 : DEC_LOG2) + 1;
    localparam logic [CNT_W-1:0]    CAL_LAST = CNT_W'((1 << CAL_LOG2) - 1);
    localparam logic [CNT_W-1:0]    DEC_LAST = CNT_W'((1 << DEC_LOG2) - 1);
    localparam logic [RAW_BITS-1:0] MID      = {1'b1, {(RAW_BITS-1){1'b0}}};
`ifdef MEAS_OFFSET_CAL_EN
    localparam fe_state_t RESET_STATE = ST_CAL;
`else
    localparam fe_state_t RESET_STATE = ST_RUN;
`endif

    // Output format is Q(STATE_BITS-1); anything else is a configuration error.
    if (STATE_Q != STATE_BITS - 1) begin : g_q_check
        $error("meas_frontend: STATE_Q must equal STATE_BITS-1");
    end

    fe_state_t state;
    fe_state_t state_next;

    logic                    accept;
    logic                    acc_clr;
    logic                    acc_load;
    logic                    grp_done;
    logic                    clip;
    logic signed [ACC_W-1:0] addend;
    logic signed [ACC_W-1:0] sum_next;
    logic [CNT_W-1:0]        cnt;
    logic [RAW_BITS-1:0]     offset;
    logic signed [RAW_BITS:0] diff;
    logic signed [31:0]      scaled;
    logic signed [31:0]      rounded;
    logic signed [31:0]      clipped;
    logic [STATE_BITS-1:0]   z_q;
    logic                    z_valid_q;

    assign bus.raw_ready = (!z_valid_q || bus.z_ready) && !recal;
    assign bus.z_out     = z_q;
    assign bus.z_valid   = z_valid_q;
    assign accept        = bus.raw_valid && bus.raw_ready;

    assign diff    = $signed({1'b0, bus.raw_in}) - $signed({1'b0, offset});
    assign scaled  = {{(32-ACC_W){sum_next[ACC_W-1]}}, sum_next} <<< SHIFT;
    assign rounded = round_shr(scaled, DEC_LOG2);
    assign clipped = saturate(rounded, STATE_BITS);
    assign clip    = (clipped != rounded);

    meas_accum #(.ACC_W(ACC_W), .CNT_W(CNT_W)) u_accum (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (acc_clr),
        .load     (acc_load),
        .addend   (addend),
        .sum_next (sum_next),
        .cnt      (cnt)
    );

`ifdef MEAS_OFFSET_CAL_EN
    localparam logic [ACC_W-1:0] CAL_HALF = ACC_W'((1 << CAL_LOG2) >> 1);
    logic [ACC_W-1:0] cal_rounded;
    assign cal_rounded = $unsigned(sum_next) + CAL_HALF;

    // Latch the rounded calibration mean on the sample that ends calibration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            offset <= MID;
        end else if (state == ST_CAL && state_next == ST_RUN) begin
            offset <= RAW_BITS'(cal_rounded >> CAL_LOG2);
        end
    end
`else
    assign offset = MID;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RESET_STATE;
        else        state <= state_next;
    end

    // Next state and accumulator control.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_next = state;
        acc_clr    = 1'b0;
        acc_load   = 1'b0;
        grp_done   = 1'b0;
        addend     = '0;
        case (state)
            ST_CAL: begin
                addend = $signed({{(ACC_W-RAW_BITS){1'b0}}, bus.raw_in});
                if (accept) begin
                    acc_load = 1'b1;
                    if (cnt == CAL_LAST) begin
                        acc_clr    = 1'b1;
                        state_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                addend = {{(ACC_W-RAW_BITS-1){diff[RAW_BITS]}}, diff};
                if (accept) begin
                    acc_load = 1'b1;
                    if (cnt == DEC_LAST) begin
                        acc_clr  = 1'b1;
                        grp_done = 1'b1;
                    end
                end
            end
            default: state_next = RESET_STATE;
        endcase
`ifdef MEAS_OFFSET_CAL_EN
        // recal drops any partial work; raw_ready is low so nothing is accepted.
        if (recal) begin
            state_next = ST_CAL;
            acc_clr    = 1'b1;
            acc_load   = 1'b0;
            grp_done   = 1'b0;
        end
`endif
    end

    // Output register, handshake, sticky saturation flag and cal_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q       <= '0;
            z_valid_q <= 1'b0;
            sat_flag  <= 1'b0;
            cal_done  <= 1'b0;
        end else begin
            if (grp_done) begin
                z_q       <= clipped[STATE_BITS-1:0];
                z_valid_q <= 1'b1;
            end else if (bus.z_ready) begin
                z_valid_q <= 1'b0;
            end
            if (recal)                 sat_flag <= 1'b0;
            else if (grp_done && clip) sat_flag <= 1'b1;
            cal_done <= (state_next == ST_RUN);
        end
    end
endmodule

// File: doc/meas_frontend.md
MEAS_FRONTEND -- requirements
Module: meas_frontend

Interface
REQ-001 SHALL have parameter RAW_BITS, default 12: width of the unsigned offset-binary raw sensor sample.
REQ-002 SHALL have parameter STATE_BITS, default 16: width of the signed output measurement.
REQ-003 SHALL have parameter STATE_Q, default 15: fractional bits of the output (Q15).
REQ-004 SHALL have parameter DEC_LOG2, default 2: log2 of the decimation/averaging factor.
REQ-005 SHALL have parameter CAL_LOG2, default 4: log2 of the number of calibration samples.
REQ-006 SHALL have port clk, input, 1: the single clock; all flops are on its rising edge.
REQ-007 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port raw_in, input, RAW_BITS: raw sample, unsigned.
REQ-009 SHALL have port raw_valid, input, 1: raw_in is valid this cycle.
REQ-010 SHALL have port raw_ready, output, 1: the block accepts raw_in this cycle.
REQ-011 SHALL have port recal, input, 1: a single-cycle pulse that restarts offset calibration.
REQ-012 SHALL have port z_out, output, STATE_BITS: signed Q15 measurement that feeds kalman_filter z_in.
REQ-013 SHALL have port z_valid, output, 1: z_out holds an unaccepted measurement.
REQ-014 SHALL have port z_ready, input, 1: downstream accepts z_out.
REQ-015 SHALL have port cal_done, output, 1: the offset is valid and the block is in RUN.
REQ-016 SHALL have port sat_flag, output, 1: sticky flag, set when any output was saturated.

Function
REQ-017 SHALL treat a raw sample as accepted only when raw_valid and raw_ready are both 1 on a rising edge.
REQ-018 SHALL drive raw_ready = (!z_valid || z_ready) && !recal, combinationally.
REQ-019 SHALL implement FSM states CAL and RUN; reset enters CAL.
REQ-020 In CAL, SHALL accumulate 2^CAL_LOG2 accepted samples unsigned, set offset = sum >> CAL_LOG2 rounded half-up, then enter RUN with cal_done=1 in the next cycle.
REQ-021 In RUN, SHALL form s = raw_in - offset as a signed (RAW_BITS+1)-bit value and accumulate s over 2^DEC_LOG2 accepted samples.
REQ-022 On the accepted sample that completes a group, SHALL compute v = round_shr(sum << (STATE_BITS-RAW_BITS), DEC_LOG2), rounding half away from zero, and saturate v to [-2^(STATE_BITS-1), 2^(STATE_BITS-1)-1].
REQ-023 SHALL register the saturated v into z_out and set z_valid on the edge after that completing sample (latency 1 cycle); the accumulator clears on that same edge.
REQ-024 SHALL hold z_out and z_valid stable while z_valid=1 and z_ready=0, and clear z_valid on the edge where z_ready=1, unless a new result loads on that same edge.
REQ-025 SHALL set sat_flag when saturation clips v; sat_flag clears only on reset or recal.
REQ-026 recal in any state SHALL discard the partial accumulation, clear cal_done and sat_flag, and enter CAL on the next edge; a pending z_valid output SHALL remain until it is accepted.
REQ-027 SHALL never assert z_valid for samples accepted in CAL.
REQ-028 The accumulator SHALL be sized so it cannot overflow: RAW_BITS+1+DEC_LOG2 bits in RUN and RAW_BITS+CAL_LOG2 bits in CAL.

Reset
REQ-029 While rst_n=0, SHALL asynchronously set z_out=0, z_valid=0, cal_done=0, sat_flag=0, offset=2^(RAW_BITS-1), accumulator=0, sample counter=0, and state=CAL.
REQ-030 Reset asserted mid-group or mid-calibration SHALL discard all partial work; no output is produced from it.

Configuration
REQ-031 With MEAS_OFFSET_CAL_EN defined, SHALL implement the CAL state, the recal input, and cal_done exactly as specified above.
REQ-032 Without MEAS_OFFSET_CAL_EN, SHALL fix offset at 2^(RAW_BITS-1), leave reset directly in RUN, tie cal_done to 1 after reset, and ignore recal (recal then only clears sat_flag).

Structure
REQ-033 Package kf_pkg SHALL hold STATE_BITS, STATE_Q, the frontend FSM state enum, and the signed round-half-away shift and saturate functions shared with kalman_filter.
REQ-034 SHALL instantiate one sub-module, meas_accum, which contains the accumulator and the sample counter with clear and load controls.

Verification (RAW_BITS=12, DEC_LOG2=2, CAL_LOG2=4, macro defined)
REQ-035 Calibration: 16 samples of 2048, then 4 samples of 3072 -> cal_done=1, z_out=16384 (0.5), z_valid=1 for a single cycle with z_ready=1.
REQ-036 Calibration rounding: 15 samples of 2048 and 1 sample of 2056 (sum 32776) -> offset=2049; then 4 samples of 2049 -> z_out=0.
REQ-037 Saturation: calibrate at 1000, then 4 samples of 4095 -> z_out=32767, sat_flag=1; calibrate at 3000, then 4 samples of 0 -> z_out=-32768.
REQ-038 Backpressure: hold z_ready=0 when a group completes -> z_out held, raw_ready=0; raise z_ready -> z_valid drops next edge, raw_ready=1.
REQ-039 recal after 2 samples of a group -> cal_done=0, the partial group is discarded, the next 16 samples recalibrate, and no z_valid occurs during CAL.
REQ-040 rst_n pulsed low mid-group -> all outputs go to reset values immediately, and the first output appears only after a full new calibration and group.
